arb_rr_sync: RTL and testbench
==============================

// Module: arb_rr_sync
// PURPOSE
//  Synchronous round-robin arbiter sharing one 4-phase req/ack channel among
//  `size` requesters. Sits between the requester-side handshakes and a single
//  shared downstream resource (ack_out driven by that resource). Holds the
//  grant for a complete 4-phase cycle (req up, ack up, req down, ack down).
//  Fair rotation: the last-served requester has lowest priority next round.
// PARAMETERS
//  size   2   number of requesters, >= 2
//  IW     $clog2(size)   width of grant index (localparam, not overridable)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  req_in     in   size   per-requester 4-phase request
//  ack_in     out  size   per-requester 4-phase acknowledge (one-hot or zero)
//  req_out    out  1      request to shared resource
//  ack_out    in   1      acknowledge from shared resource
//  grant_idx  out  IW     index of current owner (valid when busy=1)
//  busy       out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, ack_in=0, req_out=0, grant_idx=0,
//   busy=0, ptr=0. Reset overrides everything incl. mid-handshake; no output
//   glitches, all outputs registered.
//  ptr = highest-priority index; search order ptr, ptr+1, ..., size-1, 0, ...
//  FSM (one transition max per cycle):
//   IDLE: if |req_in: gnt <= first set bit in search order; grant_idx <= gnt;
//         req_out <= 1; -> REQ. Else stay.
//   REQ : wait ack_out=1; then ack_in[gnt] <= 1; -> ACK.
//   ACK : wait req_in[gnt]=0; then req_out <= 0; -> RTZ.
//   RTZ : wait ack_out=0; then ack_in[gnt] <= 0; ptr <= (gnt==size-1)?0:gnt+1;
//         -> IDLE.
//  Latency: req_in edge sampled at cycle t -> req_out=1 at t+1; ack_out=1 at
//   cycle u -> ack_in[gnt]=1 at u+1; same for falling phases. Min full cycle
//   4 clk plus resource delays. Back-to-back: next grant earliest 1 cycle
//   after ack_in drops (IDLE evaluates again).
//  Lock: only ack_in[gnt] may be 1; other requesters' req_in ignored until
//   return to IDLE. req_out never high while any ack_in still high from a
//   previous grant (guaranteed by RTZ ordering).
//  Simultaneous requests: resolved purely by ptr; ties impossible.
//  ack_out already 1 when entering REQ: accepted next cycle (level-sensitive).
//  Requester dropping req_in[gnt] while in REQ (protocol violation): ignored;
//   FSM proceeds, ACK then exits on first cycle. No deadlock.
//  ptr wraps size-1 -> 0. grant_idx holds last value in IDLE.
//  Inputs assumed synchronous to clk; no synchronisers inside.
// TESTING
//  1 rst=1 3 cycles, req_in random -> ack_in=0, req_out=0, busy=0, ptr=0.
//  2 size=2, req_in=01, resource acks 2 cycles after req_out -> req_out@t+1,
//    ack_in=01 one cycle after ack_out, full RTZ, back to IDLE, ptr=1.
//  3 size=4, req_in=1111 held, requesters return-to-zero and re-request ->
//    grant order 0,1,2,3,0; each ack_in strictly one-hot, never overlapping.
//  4 size=4, ptr=3 (after serving 2), req_in=0101 -> grant 0 (wrap), then 2.
//  5 rst asserted in ACK state (req_out=1, ack_in=0010) -> next cycle all
//    outputs 0, state IDLE, ptr=0; pending req_in=0010 granted again after.
//  6 ack_out held 1 before request arrives -> REQ lasts 1 cycle; RTZ waits
//    until ack_out falls; no second grant issued while ack_out=1.

Source files
------------

// File: rtl/arb_rr_sync.sv
// arb_rr_sync: round-robin arbiter sharing one 4-phase req/ack channel among size requesters
module arb_rr_sync #(
    parameter int size = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [size-1:0]           req_in,
    output logic [size-1:0]           ack_in,
    output logic                      req_out,
    input  logic                      ack_out,
    output logic [$clog2(size)-1:0]   grant_idx,
    output logic                      busy
);
    localparam int IW = $clog2(size);

    typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} state_t;

    state_t          state_q, state_d;
    logic [size-1:0] ack_q, ack_d;
    logic            req_out_q, req_out_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   pick;

    // first active requester in rotating order ptr, ptr+1, ..., wrapping to 0
    always_comb begin
        int j;
        logic found;
        j = 0;
        found = 1'b0;
        pick = ptr_q;
        for (int i = 0; i < size; i++) begin
            j = int'(ptr_q) + i;
            j = (j >= size) ? j - size : j;
            if (!found && req_in[j]) begin
                pick = IW'(j);
                found = 1'b1;
            end
        end
    end

    // all state and outputs are registered; reset wins over any handshake phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            req_out_q <= 1'b0;
            gnt_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            req_out_q <= req_out_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
        end
    end

    // next state: one phase of the 4-phase cycle per transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (|req_in)       ? REQ  : IDLE;
            REQ:     state_d = ack_out         ? ACK  : REQ;
            ACK:     state_d = !req_in[gnt_q]  ? RTZ  : ACK;
            default: state_d = !ack_out        ? IDLE : RTZ;
        endcase
    end

    // next output values; the granted index and ptr only move at grant and release
    always_comb begin
        ack_d     = ack_q;
        req_out_d = req_out_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: if (|req_in) begin
                gnt_d     = pick;
                req_out_d = 1'b1;
            end
            REQ: if (ack_out) begin
                ack_d        = '0;
                ack_d[gnt_q] = 1'b1;
            end
            ACK: if (!req_in[gnt_q]) req_out_d = 1'b0;
            default: if (!ack_out) begin
                ack_d = '0;
                ptr_d = (gnt_q == IW'(size - 1)) ? '0 : gnt_q + 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign ack_in    = ack_q;
    assign req_out   = req_out_q;
    assign grant_idx = gnt_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_arb_rr_sync.sv
// tb_arb_rr_sync: directed bench for two-way and four-way round-robin arbiters
module tb_arb_rr_sync;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_in2 = '0;
    logic [1:0] ack_in2;
    logic       req_out2;
    logic       ack_out2 = 1'b0;
    logic       gidx2;
    logic       busy2;
    logic [3:0] req_in4 = '0;
    logic [3:0] ack_in4;
    logic       req_out4;
    logic       ack_out4 = 1'b0;
    logic [1:0] gidx4;
    logic       busy4;
    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    arb_rr_sync #(.size(2)) u2 (
        .clk(clk), .rst(rst), .req_in(req_in2), .ack_in(ack_in2),
        .req_out(req_out2), .ack_out(ack_out2), .grant_idx(gidx2), .busy(busy2)
    );

    arb_rr_sync #(.size(4)) u4 (
        .clk(clk), .rst(rst), .req_in(req_in4), .ack_in(ack_in4),
        .req_out(req_out4), .ack_out(ack_out4), .grant_idx(gidx4), .busy(busy4)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic serve4(input int exp, input bit reraise);
        int n = 0;
        while (req_out4 !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        ncmp++;
        if (req_out4 !== 1'b1) begin nerr++; $display("FAIL serve4_req_out grant %0d: got %b want 1", exp, req_out4); end
        ncmp++;
        if (gidx4 !== 2'(exp)) begin nerr++; $display("FAIL serve4_grant_idx: got %0d want %0d", gidx4, exp); end
        ncmp++;
        if (ack_in4 !== 4'b0) begin nerr++; $display("FAIL serve4_ack_pre grant %0d: got %b want 0000", exp, ack_in4); end
        ack_out4 = 1'b1;
        @(negedge clk);
        ncmp++;
        if (ack_in4 !== 4'(1 << exp)) begin nerr++; $display("FAIL serve4_ack_up: got %b want %b", ack_in4, 4'(1 << exp)); end
        req_in4[exp] = 1'b0;
        @(negedge clk);
        ncmp++;
        if (req_out4 !== 1'b0 || ack_in4 !== 4'(1 << exp)) begin nerr++; $display("FAIL serve4_req_down: req_out %b ack_in %b want 0 %b", req_out4, ack_in4, 4'(1 << exp)); end
        ack_out4 = 1'b0;
        @(negedge clk);
        ncmp++;
        if (ack_in4 !== 4'b0 || busy4 !== 1'b0) begin nerr++; $display("FAIL serve4_release: ack_in %b busy %b want 0000 0", ack_in4, busy4); end
        if (reraise) req_in4[exp] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_in2 = 2'($urandom_range(0, 3));
            req_in4 = 4'($urandom_range(0, 15));
            @(negedge clk);
            ncmp++;
            if ({ack_in2, req_out2, busy2, gidx2} !== 5'b0) begin nerr++; $display("FAIL reset_u2: got %b want 00000", {ack_in2, req_out2, busy2, gidx2}); end
            ncmp++;
            if ({ack_in4, req_out4, busy4, gidx4} !== 8'b0) begin nerr++; $display("FAIL reset_u4: got %b want 00000000", {ack_in4, req_out4, busy4, gidx4}); end
            ncmp++;
            if (u2.ptr_q !== 1'b0 || u4.ptr_q !== 2'd0) begin nerr++; $display("FAIL reset_ptr: got %0d %0d want 0 0", u2.ptr_q, u4.ptr_q); end
        end
        req_in2 = '0;
        req_in4 = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single2();
        req_in2 = 2'b01;
        @(negedge clk);
        ncmp++;
        if (req_out2 !== 1'b1 || busy2 !== 1'b1 || gidx2 !== 1'b0 || ack_in2 !== 2'b00) begin nerr++; $display("FAIL single_grant: req_out %b busy %b idx %b ack %b want 1 1 0 00", req_out2, busy2, gidx2, ack_in2); end
        @(negedge clk);
        ncmp++;
        if (ack_in2 !== 2'b00) begin nerr++; $display("FAIL single_wait: ack %b want 00", ack_in2); end
        ack_out2 = 1'b1;
        @(negedge clk);
        ncmp++;
        if (ack_in2 !== 2'b01 || req_out2 !== 1'b1) begin nerr++; $display("FAIL single_ack: ack %b req_out %b want 01 1", ack_in2, req_out2); end
        req_in2 = 2'b00;
        @(negedge clk);
        ncmp++;
        if (req_out2 !== 1'b0 || ack_in2 !== 2'b01) begin nerr++; $display("FAIL single_rtz: req_out %b ack %b want 0 01", req_out2, ack_in2); end
        ack_out2 = 1'b0;
        @(negedge clk);
        ncmp++;
        if (ack_in2 !== 2'b00 || busy2 !== 1'b0 || gidx2 !== 1'b0) begin nerr++; $display("FAIL single_idle: ack %b busy %b idx %b want 00 0 0", ack_in2, busy2, gidx2); end
        ncmp++;
        if (u2.ptr_q !== 1'b1) begin nerr++; $display("FAIL single_ptr: got %0d want 1", u2.ptr_q); end
    endtask

    task automatic test_rotation();
        do_reset();
        req_in4 = 4'b1111;
        serve4(0, 1'b1);
        serve4(1, 1'b1);
        serve4(2, 1'b1);
        serve4(3, 1'b1);
        serve4(0, 1'b0);
        ncmp++;
        if (u4.ptr_q !== 2'd1) begin nerr++; $display("FAIL rotation_ptr: got %0d want 1", u4.ptr_q); end
        req_in4 = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        req_in4 = 4'b0100;
        serve4(2, 1'b0);
        ncmp++;
        if (u4.ptr_q !== 2'd3) begin nerr++; $display("FAIL wrap_ptr3: got %0d want 3", u4.ptr_q); end
        req_in4 = 4'b0101;
        serve4(0, 1'b0);
        serve4(2, 1'b0);
        ncmp++;
        if (u4.ptr_q !== 2'd3) begin nerr++; $display("FAIL wrap_ptr_end: got %0d want 3", u4.ptr_q); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_in4 = 4'b0010;
        @(negedge clk);
        ack_out4 = 1'b1;
        @(negedge clk);
        ncmp++;
        if (ack_in4 !== 4'b0010 || req_out4 !== 1'b1) begin nerr++; $display("FAIL midrst_ack_state: ack %b req_out %b want 0010 1", ack_in4, req_out4); end
        rst = 1'b1;
        @(negedge clk);
        ncmp++;
        if ({ack_in4, req_out4, busy4, gidx4} !== 8'b0 || u4.ptr_q !== 2'd0) begin nerr++; $display("FAIL midrst_clear: outs %b ptr %0d want 00000000 0", {ack_in4, req_out4, busy4, gidx4}, u4.ptr_q); end
        rst = 1'b0;
        ack_out4 = 1'b0;
        serve4(1, 1'b0);
    endtask

    task automatic test_early_ack();
        do_reset();
        ack_out2 = 1'b1;
        req_in2 = 2'b10;
        @(negedge clk);
        ncmp++;
        if (req_out2 !== 1'b1 || gidx2 !== 1'b1 || ack_in2 !== 2'b00) begin nerr++; $display("FAIL early_grant: req_out %b idx %b ack %b want 1 1 00", req_out2, gidx2, ack_in2); end
        @(negedge clk);
        ncmp++;
        if (ack_in2 !== 2'b10) begin nerr++; $display("FAIL early_ack_1cyc: ack %b want 10", ack_in2); end
        req_in2 = 2'b00;
        @(negedge clk);
        ncmp++;
        if (req_out2 !== 1'b0) begin nerr++; $display("FAIL early_req_down: got %b want 0", req_out2); end
        req_in2 = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ncmp++;
            if (busy2 !== 1'b1 || ack_in2 !== 2'b10 || req_out2 !== 1'b0) begin nerr++; $display("FAIL early_rtz_hold: busy %b ack %b req_out %b want 1 10 0", busy2, ack_in2, req_out2); end
        end
        ack_out2 = 1'b0;
        @(negedge clk);
        ncmp++;
        if (ack_in2 !== 2'b00 || busy2 !== 1'b0) begin nerr++; $display("FAIL early_release: ack %b busy %b want 00 0", ack_in2, busy2); end
        @(negedge clk);
        ncmp++;
        if (req_out2 !== 1'b1 || gidx2 !== 1'b0) begin nerr++; $display("FAIL early_next_grant: req_out %b idx %b want 1 0", req_out2, gidx2); end
        req_in2 = 2'b00;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single2();
        test_rotation();
        test_wrap();
        test_reset_mid();
        test_early_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
